// File: rtl/ft_fifo_wr_arbiter.sv
// Round-robin arbiter sharing the FT2232H async-FIFO write port among four byte sources.
// Optional statistics counters are enabled with the FT_ARB_STATS_EN macro.
module ft_fifo_wr_arbiter #(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req_valid,
    input  logic [31:0] req_data,
    output logic [3:0]  req_ready,
    output logic [7:0]  d,
    output logic        wr,
    input  logic        txe,
    output logic        busy,
    output logic [1:0]  grant_id
`ifdef FT_ARB_STATS_EN
    ,
    output logic [15:0] byte_count,
    output logic [15:0] stall_count
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } state_t;

    localparam logic [7:0] SETUP_LAST  = 8'(SETUP_CYC - 1);
    localparam logic [7:0] STROBE_LAST = 8'(STROBE_CYC - 1);
    localparam logic [7:0] HOLD_LAST   = 8'(HOLD_CYC - 1);

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic [1:0]  r_last;
    logic [7:0]  r_d;
    logic        r_wr;
    logic        r_busy;
    logic [1:0]  r_grant_id;

    logic        w_found;
    logic [1:0]  w_grant;
    logic [1:0]  w_idx;
    logic [7:0]  w_byte;
    logic        w_accept;
    logic        w_last_strobe;

    // Search starts one past the previous winner; k == 4 wraps back to r_last itself.
    always_comb begin
        w_found = 1'b0;
        w_grant = r_last;
        w_idx   = r_last;
        for (int unsigned k = 1; k <= 4; k++) begin
            w_idx = r_last + 2'(k);
            if (!w_found && req_valid[w_idx]) begin
                w_grant = w_idx;
                w_found = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (r_state == IDLE && !txe && !rst && w_found) begin
            req_ready = 4'b0001 << w_grant;
        end
    end

    assign w_byte        = req_data[{w_grant, 3'b000} +: 8];
    assign w_accept      = |(req_valid & req_ready);
    assign w_last_strobe = (r_state == STROBE) && (r_cnt == STROBE_LAST);

    // wr is updated on the same edge as the state, so it is low exactly while in STROBE.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_last     <= 2'd3;
            r_d        <= '0;
            r_wr       <= 1'b1;
            r_busy     <= 1'b0;
            r_grant_id <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_d        <= w_byte;
                        r_grant_id <= w_grant;
                        r_last     <= w_grant;
                        r_cnt      <= '0;
                        r_busy     <= 1'b1;
                        r_state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_wr    <= 1'b0;
                        r_state <= STROBE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                STROBE: begin
                    if (w_last_strobe) begin
                        r_cnt   <= '0;
                        r_wr    <= 1'b1;
                        r_state <= HOLD;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: begin
                    r_cnt   <= '0;
                    r_wr    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign d        = r_d;
    assign wr       = r_wr;
    assign busy     = r_busy;
    assign grant_id = r_grant_id;

`ifdef FT_ARB_STATS_EN
    logic [15:0] r_byte_count;
    logic [15:0] r_stall_count;

    // byte_count wraps naturally; stall_count saturates.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_byte_count  <= '0;
            r_stall_count <= '0;
        end else begin
            if (w_last_strobe) begin
                r_byte_count <= r_byte_count + 16'd1;
            end
            if (r_state == IDLE && (|req_valid) && txe && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + 16'd1;
            end
        end
    end

    assign byte_count  = r_byte_count;
    assign stall_count = r_stall_count;
`endif

endmodule
